pmem_rr_ctrl: RTL and testbench

Two-port round-robin controller that shares one parity-protected memory (9-bit words: 8 data + even-parity bit) between requester A and requester B. It accepts one read or write at a time, drives the memory's read/write/address/data strobes, and returns read data with a parity-error flag. It also keeps a saturating count of parity errors. It sits between the requesting agents and the memory datapath.

---
 rtl/pmem_pkg.sv | 33 +++
 rtl/rr_arb2.sv | 31 +++
 rtl/pmem_rr_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pmem_rr_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// rtl/pmem_pkg.sv - shared types and helpers for the parity-memory round-robin controller
//
// Contents:
//   state_t   : controller FSM states (IDLE, ISSUE, WAIT, RESP)
//   owner_t   : which requester owns the current transfer (OWN_A, OWN_B)
//   DATA_W    : native data width that even_par() operates on
//   PERR_MAX  : saturation value of the parity-error counter
//   even_par  : returns {parity, data} with the parity bit chosen so the word has even parity

package pmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  localparam int         DATA_W   = 8;
  localparam logic [7:0] PERR_MAX = 8'hFF;

  // The stored word carries an extra bit that makes the total count of ones even,
  // so XOR-reducing a clean word always yields 0.
  function automatic logic [DATA_W:0] even_par(input logic [DATA_W-1:0] data);
    return {^data, data};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter
//
// Ports:
//   req        in   2  request vector, bit 0 = requester A, bit 1 = requester B
//   last_grant in   1  owner of the most recent grant (loser of the next tie wins)
//   en         in   1  arbitration enable; gnt is all-zero when low
//   gnt        out  2  one-hot grant, same bit order as req

module rr_arb2
  import pmem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  // A wins when it is alone or when B had the last turn; otherwise B takes any
  // request it has. This yields strict alternation under constant contention.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || last_grant == OWN_B)) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

endmodule

// File: rtl/pmem_rr_ctrl.sv
// rtl/pmem_rr_ctrl.sv - round-robin controller sharing one parity-protected memory between two requesters
//
// Parameters:
//   AW      address width
//   DW      data width; memory words are DW+1 bits {parity, data}
//   RD_LAT  cycles from the mem_read cycle to valid mem_rdata (1..7)
//
// Ports:
//   pclk                  in   1     clock, rising edge
//   reset                 in   1     synchronous, active-high
//   a_valid/b_valid       in   1     command valid
//   a_we/b_we             in   1     1 = write, 0 = read
//   a_addr/b_addr         in   AW    command address
//   a_wdata/b_wdata       in   DW    write data
//   a_ready/b_ready       out  1     command accepted this cycle (combinational)
//   a_rsp_valid/b_rsp_valid out 1    one-cycle response pulse to the owner
//   rsp_rdata             out  DW    read data, qualified by x_rsp_valid
//   rsp_perr              out  1     parity error on this response
//   mem_write/mem_read    out  1     one-cycle memory strobes
//   mem_addr              out  AW    memory address (held between transfers)
//   mem_wdata             out  DW+1  {parity, data} to memory (held between writes)
//   mem_rdata             in   DW+1  {parity, data} from memory
//   busy                  out  1     a transfer is in flight
//   perr_cnt              out  8     saturating parity-error count

module pmem_rr_ctrl
  import pmem_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ready,
  output logic          a_rsp_valid,
  input  logic          b_valid,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ready,
  output logic          b_rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_perr,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW:0]   mem_wdata,
  input  logic [DW:0]   mem_rdata,
  output logic          busy,
  output logic [7:0]    perr_cnt
);

  localparam int CNT_W = 3;

  state_t            state;
  owner_t            owner;
  owner_t            last_grant;
  logic              lat_we;
  logic [CNT_W-1:0]  wait_cnt;

  logic [1:0]        gnt;
  logic              arb_en;
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic [DW:0]       sel_word;
  logic              rd_perr;

  // Arbitration is only meaningful while no transfer is in flight.
  assign arb_en = (state == IDLE);

  rr_arb2 u_arb (
    .req        ({b_valid, a_valid}),
    .last_grant (last_grant),
    .en         (arb_en),
    .gnt        (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  // Payload of whichever requester is granted this cycle.
  always_comb begin
    sel_we    = a_we;
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    if (gnt[1]) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  // The package helper is sized for the native data width; other widths fall
  // back to the same formula written out.
  generate
    if (DW == DATA_W) begin : g_par_pkg
      assign sel_word = even_par(sel_wdata);
    end else begin : g_par_gen
      assign sel_word = {^sel_wdata, sel_wdata};
    end
  endgenerate

  // A clean word XOR-reduces to 0; any odd number of flipped bits shows as 1.
  assign rd_perr = ^mem_rdata;

  // The accept edge loads the memory strobes directly, so they are high during
  // the ISSUE cycle and fall automatically on the following edge. mem_addr and
  // mem_wdata are loaded only on accept so they hold between transfers.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_A;
      last_grant  <= OWN_B;
      lat_we      <= 1'b0;
      wait_cnt    <= '0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      rsp_rdata   <= '0;
      rsp_perr    <= 1'b0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      perr_cnt    <= '0;
    end else begin
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      rsp_perr    <= 1'b0;

      case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            owner      <= gnt[1] ? OWN_B : OWN_A;
            last_grant <= gnt[1] ? OWN_B : OWN_A;
            lat_we     <= sel_we;
            mem_addr   <= sel_addr;
            if (sel_we) begin
              mem_wdata <= sel_word;
              mem_write <= 1'b1;
            end else begin
              mem_read  <= 1'b1;
            end
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (lat_we) begin
            a_rsp_valid <= (owner == OWN_A);
            b_rsp_valid <= (owner == OWN_B);
            rsp_rdata   <= '0;
            state       <= RESP;
          end else begin
            // Counting down from RD_LAT-1 spends exactly RD_LAT cycles in WAIT,
            // the last of which is when the memory presents its data.
            wait_cnt <= CNT_W'(RD_LAT - 1);
            state    <= WAIT;
          end
        end

        WAIT: begin
          if (wait_cnt == '0) begin
            a_rsp_valid <= (owner == OWN_A);
            b_rsp_valid <= (owner == OWN_B);
            rsp_rdata   <= mem_rdata[DW-1:0];
            rsp_perr    <= rd_perr;
            if (rd_perr && perr_cnt != PERR_MAX) begin
              perr_cnt <= perr_cnt + 8'd1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_rr_ctrl.sv
// tb/tb_pmem_rr_ctrl.sv - self-checking bench for pmem_rr_ctrl (RD_LAT=1 and RD_LAT=4 instances)

module tb_pmem_rr_ctrl;

  localparam int AW = 16;
  localparam int DW = 8;

  logic pclk = 1'b0;
  logic reset;

  // Index 0 = instance with RD_LAT=1, index 1 = instance with RD_LAT=4.
  logic [1:0]    a_valid, a_we, a_ready, a_rsp_valid;
  logic [1:0]    b_valid, b_we, b_ready, b_rsp_valid;
  logic [1:0]    rsp_perr, mem_write, mem_read, busy;
  logic [AW-1:0] a_addr [2];
  logic [AW-1:0] b_addr [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] a_wdata [2];
  logic [DW-1:0] b_wdata [2];
  logic [DW-1:0] rsp_rdata [2];
  logic [DW:0]   mem_wdata [2];
  logic [DW:0]   mem_rdata [2];
  logic [7:0]    perr_cnt [2];

  pmem_rr_ctrl #(.AW(AW), .DW(DW), .RD_LAT(1)) dut_lat1 (
    .pclk(pclk), .reset(reset),
    .a_valid(a_valid[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
    .a_ready(a_ready[0]), .a_rsp_valid(a_rsp_valid[0]),
    .b_valid(b_valid[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
    .b_ready(b_ready[0]), .b_rsp_valid(b_rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_perr(rsp_perr[0]),
    .mem_write(mem_write[0]), .mem_read(mem_read[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0]), .perr_cnt(perr_cnt[0])
  );

  pmem_rr_ctrl #(.AW(AW), .DW(DW), .RD_LAT(4)) dut_lat4 (
    .pclk(pclk), .reset(reset),
    .a_valid(a_valid[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
    .a_ready(a_ready[1]), .a_rsp_valid(a_rsp_valid[1]),
    .b_valid(b_valid[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
    .b_ready(b_ready[1]), .b_rsp_valid(b_rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_perr(rsp_perr[1]),
    .mem_write(mem_write[1]), .mem_read(mem_read[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1]), .perr_cnt(perr_cnt[1])
  );

  always #5 pclk = ~pclk;

  // Memory device model: 256 words decoded from addr[7:0], fixed read latency
  // per instance, junk (bad-parity) data whenever no read result is due.
  bit   [8:0] mem_store [2][256];
  bit   [8:0] pipe_d [2][4];
  bit   [3:0] pipe_v [2];
  logic [1:0] inj_en;
  logic [7:0] inj_addr [2];
  logic [8:0] inj_word [2];

  always @(posedge pclk) begin
    for (int g = 0; g < 2; g++) begin
      if (mem_write[g] === 1'b1) mem_store[g][mem_addr[g][7:0]] <= mem_wdata[g];
      pipe_v[g] <= {pipe_v[g][2:0], mem_read[g] === 1'b1};
      pipe_d[g][0] <= (inj_en[g] && mem_addr[g][7:0] == inj_addr[g]) ? inj_word[g]
                                                                    : mem_store[g][mem_addr[g][7:0]];
      for (int k = 1; k < 4; k++) pipe_d[g][k] <= pipe_d[g][k-1];
    end
  end

  assign mem_rdata[0] = pipe_v[0][0] ? pipe_d[0][0] : 9'h1FF;
  assign mem_rdata[1] = pipe_v[1][3] ? pipe_d[1][3] : 9'h1FF;

  // Reference model: expected memory contents and expected error count.
  byte unsigned ref_mem [2][256];
  int           ref_perr [2];
  int           n_cmp;
  int           n_fail;
  string        grant_order;
  int           acc_cyc [$];

  task automatic drive_req(input int d, input bit use_b, input bit v, input bit we,
                           input logic [15:0] addr, input logic [7:0] wd);
    if (use_b) begin
      b_valid[d] = v; b_we[d] = we; b_addr[d] = addr; b_wdata[d] = wd;
    end else begin
      a_valid[d] = v; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wd;
    end
  endtask

  function automatic bit rdy(input int d, input bit use_b);
    return use_b ? (b_ready[d] === 1'b1) : (a_ready[d] === 1'b1);
  endfunction

  // One complete transfer with response timing and content checks.
  task automatic txn(input int d, input bit use_b, input bit we,
                     input logic [15:0] addr, input logic [7:0] wd);
    int         lat, due;
    bit         got;
    logic [8:0] word;
    logic [7:0] exp_d;
    logic       exp_p;
    logic [1:0] exp_v;
    lat = (d == 0) ? 1 : 4;
    if (!we && inj_en[d] && addr[7:0] == inj_addr[d]) begin
      exp_d = inj_word[d][7:0];
      exp_p = ^inj_word[d];
    end else begin
      exp_d = we ? 8'h00 : ref_mem[d][addr[7:0]];
      exp_p = 1'b0;
    end
    exp_v = use_b ? 2'b10 : 2'b01;
    @(negedge pclk);
    drive_req(d, use_b, 1'b1, we, addr, wd);
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      #1;
      if (rdy(d, use_b)) got = 1'b1;
      else @(negedge pclk);
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL txn_ready: dut %0d no ready within 16 cycles, required ready=1", d);
      drive_req(d, use_b, 1'b0, 1'b0, 16'h0, 8'h0);
      return;
    end
    @(negedge pclk);
    drive_req(d, use_b, 1'b0, 1'b0, 16'h0, 8'h0);
    n_cmp++;
    if ({mem_write[d], mem_read[d], busy[d]} !== {we, !we, 1'b1} || mem_addr[d] !== addr) begin
      n_fail++;
      $display("FAIL txn_issue: dut %0d wr/rd/busy=%b addr=%h, required %b addr=%h",
               d, {mem_write[d], mem_read[d], busy[d]}, mem_addr[d], {we, !we, 1'b1}, addr);
    end
    if (we) begin
      word = {^wd, wd};
      n_cmp++;
      if (mem_wdata[d] !== word) begin
        n_fail++;
        $display("FAIL txn_wdata: dut %0d mem_wdata=%h, required %h", d, mem_wdata[d], word);
      end
    end
    due = we ? 2 : 2 + lat;
    for (int k = 2; k <= due; k++) begin
      @(negedge pclk);
      n_cmp++;
      if (k < due) begin
        if ({b_rsp_valid[d], a_rsp_valid[d], mem_write[d], mem_read[d]} !== 4'b0000 || busy[d] !== 1'b1) begin
          n_fail++;
          $display("FAIL txn_gap: dut %0d cycle %0d rsp/strobes=%b busy=%b, required 0000 busy=1",
                   d, k, {b_rsp_valid[d], a_rsp_valid[d], mem_write[d], mem_read[d]}, busy[d]);
        end
      end else begin
        if ({b_rsp_valid[d], a_rsp_valid[d]} !== exp_v || rsp_rdata[d] !== exp_d || rsp_perr[d] !== exp_p) begin
          n_fail++;
          $display("FAIL txn_rsp: dut %0d cycle %0d valid=%b rdata=%h perr=%b, required valid=%b rdata=%h perr=%b",
                   d, k, {b_rsp_valid[d], a_rsp_valid[d]}, rsp_rdata[d], rsp_perr[d], exp_v, exp_d, exp_p);
        end
      end
    end
    if (we) ref_mem[d][addr[7:0]] = wd;
    if (exp_p && ref_perr[d] < 255) ref_perr[d]++;
    n_cmp++;
    if (perr_cnt[d] !== 8'(ref_perr[d])) begin
      n_fail++;
      $display("FAIL txn_perr_cnt: dut %0d perr_cnt=%0d, required %0d", d, perr_cnt[d], ref_perr[d]);
    end
  endtask

  // Streams na writes from A and nb writes from B, each requester holding valid
  // until its last request is accepted; records grant order and accept cycles.
  task automatic run_stream(input int d, input int na, input int nb);
    int         left_a, left_b, due_a, due_b;
    bit         acc_a, acc_b, done;
    logic [7:0] da, db;
    left_a = na; left_b = nb; due_a = -1; due_b = -1; done = 1'b0;
    grant_order = "";
    acc_cyc.delete();
    @(negedge pclk);
    da = 8'($urandom); db = 8'($urandom);
    if (left_a > 0) drive_req(d, 1'b0, 1'b1, 1'b1, 16'h0040 + 16'(left_a), da);
    if (left_b > 0) drive_req(d, 1'b1, 1'b1, 1'b1, 16'h0060 + 16'(left_b), db);
    for (int cyc = 0; cyc < 80; cyc++) begin
      n_cmp++;
      if (a_rsp_valid[d] !== (cyc == due_a) || b_rsp_valid[d] !== (cyc == due_b)) begin
        n_fail++;
        $display("FAIL stream_rsp: cycle %0d a=%b b=%b, required a=%b b=%b",
                 cyc, a_rsp_valid[d], b_rsp_valid[d], cyc == due_a, cyc == due_b);
      end
      if (left_a == 0 && left_b == 0 && cyc >= due_a && cyc >= due_b) begin
        done = 1'b1;
        break;
      end
      #1;
      acc_a = a_valid[d] && (a_ready[d] === 1'b1);
      acc_b = b_valid[d] && (b_ready[d] === 1'b1);
      n_cmp++;
      if (acc_a && acc_b) begin
        n_fail++;
        $display("FAIL stream_onehot: cycle %0d both readies high, required at most one", cyc);
      end
      if (acc_a) begin
        grant_order = {grant_order, "A"};
        acc_cyc.push_back(cyc);
        due_a = cyc + 2;
        ref_mem[d][8'(16'h0040 + 16'(left_a))] = da;
        left_a--;
      end
      if (acc_b) begin
        grant_order = {grant_order, "B"};
        acc_cyc.push_back(cyc);
        due_b = cyc + 2;
        ref_mem[d][8'(16'h0060 + 16'(left_b))] = db;
        left_b--;
      end
      @(negedge pclk);
      if (acc_a) begin
        da = 8'($urandom);
        if (left_a > 0) drive_req(d, 1'b0, 1'b1, 1'b1, 16'h0040 + 16'(left_a), da);
        else drive_req(d, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      end
      if (acc_b) begin
        db = 8'($urandom);
        if (left_b > 0) drive_req(d, 1'b1, 1'b1, 1'b1, 16'h0060 + 16'(left_b), db);
        else drive_req(d, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
      end
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL stream_timeout: %0d A and %0d B requests left after 80 cycles, required 0", left_a, left_b);
      drive_req(d, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      drive_req(d, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({busy[d], mem_write[d], mem_read[d], a_rsp_valid[d], b_rsp_valid[d], rsp_perr[d]} !== 6'b0 ||
          perr_cnt[d] !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_ctrl: dut %0d flags=%b perr_cnt=%h, required 0", d,
                 {busy[d], mem_write[d], mem_read[d], a_rsp_valid[d], b_rsp_valid[d], rsp_perr[d]}, perr_cnt[d]);
      end
      n_cmp++;
      if (mem_addr[d] !== 16'h0 || mem_wdata[d] !== 9'h0 || rsp_rdata[d] !== 8'h0) begin
        n_fail++;
        $display("FAIL reset_data: dut %0d addr=%h wdata=%h rdata=%h, required 0", d,
                 mem_addr[d], mem_wdata[d], rsp_rdata[d]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    txn(0, 1'b0, 1'b1, 16'h0010, 8'hA5);
    txn(0, 1'b0, 1'b0, 16'h0010, 8'h00);
  endtask

  task automatic test_parity_calc();
    txn(0, 1'b0, 1'b1, 16'h0011, 8'h01);
    txn(0, 1'b1, 1'b1, 16'h0012, 8'h03);
    txn(0, 1'b0, 1'b0, 16'h0011, 8'h00);
    txn(0, 1'b1, 1'b0, 16'h0012, 8'h00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      txn(i % 4 == 3 ? 1 : 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          {8'($urandom), 8'($urandom_range(0, 7))}, 8'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    run_stream(0, 3, 0);
    n_cmp++;
    if (grant_order != "AAA" || acc_cyc.size() != 3 ||
        acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
      n_fail++;
      $display("FAIL b2b_a: order=%s accepts=%p, required AAA spaced 3", grant_order, acc_cyc);
    end
    run_stream(0, 0, 2);
    n_cmp++;
    if (grant_order != "BB" || acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 3) begin
      n_fail++;
      $display("FAIL b2b_b: order=%s accepts=%p, required BB spaced 3", grant_order, acc_cyc);
    end
  endtask

  task automatic test_contention();
    run_stream(0, 2, 2);
    n_cmp++;
    if (grant_order != "ABAB") begin
      n_fail++;
      $display("FAIL contention_order: order=%s, required ABAB", grant_order);
    end
  endtask

  task automatic test_parity_error();
    inj_en[0] = 1'b1; inj_addr[0] = 8'h20; inj_word[0] = 9'h1A5;
    txn(0, 1'b0, 1'b0, 16'h0020, 8'h00);
    n_cmp++;
    if (perr_cnt[0] !== 8'd1) begin
      n_fail++;
      $display("FAIL perr_first: perr_cnt=%0d, required 1", perr_cnt[0]);
    end
    for (int i = 1; i < 300; i++) txn(0, 1'(i % 2), 1'b0, 16'h0020, 8'h00);
    n_cmp++;
    if (perr_cnt[0] !== 8'hFF) begin
      n_fail++;
      $display("FAIL perr_saturate: perr_cnt=%h, required ff", perr_cnt[0]);
    end
    inj_en[0] = 1'b0;
  endtask

  task automatic test_rdlat4();
    txn(1, 1'b1, 1'b1, 16'h1234, 8'h5C);
    txn(1, 1'b1, 1'b0, 16'h1234, 8'h00);
    inj_en[1] = 1'b1; inj_addr[1] = 8'h77; inj_word[1] = 9'h1A5;
    txn(1, 1'b1, 1'b0, 16'h0077, 8'h00);
    inj_en[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit got;
    @(negedge pclk);
    drive_req(1, 1'b0, 1'b1, 1'b0, 16'h1234, 8'h00);
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      #1;
      if (a_ready[1] === 1'b1) got = 1'b1;
      else @(negedge pclk);
    end
    @(negedge pclk);
    drive_req(1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge pclk);
    n_cmp++;
    if (!got || busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_inflight: accepted=%b busy=%b, required 1 1", got, busy[1]);
    end
    reset = 1'b1;
    @(negedge pclk);
    n_cmp++;
    if ({busy[1], mem_read[1], a_rsp_valid[1], b_rsp_valid[1]} !== 4'b0 || perr_cnt[1] !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_state: busy/rd/rsp=%b perr_cnt=%0d, required 0000 0",
               {busy[1], mem_read[1], a_rsp_valid[1], b_rsp_valid[1]}, perr_cnt[1]);
    end
    reset = 1'b0;
    ref_perr[0] = 0; ref_perr[1] = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      n_cmp++;
      if ({busy[1], a_rsp_valid[1], b_rsp_valid[1]} !== 3'b0) begin
        n_fail++;
        $display("FAIL rstmid_quiet: cycle %0d busy/rsp=%b, required 000", i,
                 {busy[1], a_rsp_valid[1], b_rsp_valid[1]});
      end
    end
    drive_req(1, 1'b0, 1'b1, 1'b0, 16'h0001, 8'h00);
    drive_req(1, 1'b1, 1'b1, 1'b0, 16'h0002, 8'h00);
    #1;
    n_cmp++;
    if ({a_ready[1], b_ready[1]} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_tie: a_ready/b_ready=%b, required 10", {a_ready[1], b_ready[1]});
    end
    drive_req(1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive_req(1, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    repeat (2) @(negedge pclk);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    ref_perr[0] = 0; ref_perr[1] = 0;
    inj_en = 2'b00;
    for (int d = 0; d < 2; d++) begin
      inj_addr[d] = 8'h00; inj_word[d] = 9'h000;
      drive_req(d, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      drive_req(d, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    end
    reset = 1'b1;
    test_reset();
    test_write_read();
    test_parity_calc();
    test_random();
    test_back_to_back();
    test_contention();
    test_parity_error();
    test_rdlat4();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
